// File: rtl/mmio_arb_pkg.sv
// Shared types and default widths for the two-master MMIO arbiter.
package mmio_arb_pkg;
  localparam int unsigned DEF_ADDR_W = 21;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    ACK  = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the master that wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

  // After a grant the pointer moves to the master that was not granted.
  always_ff @(posedge clk) begin
    if (reset) ptr <= 1'b0;
    else if (advance && (gnt != 2'b00)) ptr <= gnt[0];
  end
endmodule

// File: rtl/mmio_arbiter.sv
// Arbitrates two MMIO masters onto one FPro bus: grant, one bus cycle, one ack cycle.
module mmio_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             m_req,
  input  logic [1:0]             m_wr,
  input  logic [1:0][ADDR_W-1:0] m_addr,
  input  logic [1:0][DATA_W-1:0] m_wr_data,
  output logic [1:0]             m_ack,
  output logic [DATA_W-1:0]      m_rd_data,
  output logic                   mmio_cs,
  output logic                   mmio_wr,
  output logic                   mmio_rd,
  output logic [ADDR_W-1:0]      mmio_addr,
  output logic [DATA_W-1:0]      mmio_wr_data,
  input  logic [DATA_W-1:0]      mmio_rd_data
);
  state_t     state, state_nxt;
  logic       take;
  logic [1:0] gnt;
  logic       gnt_idx;
  logic       sel;
  logic       cmd_wr;

  assign gnt_idx = gnt[1];

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (m_req),
    .advance (take),
    .gnt     (gnt)
  );

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: if (m_req != 2'b00) begin
        take      = 1'b1;
        state_nxt = BUS;
      end
      BUS:     state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Strobes and ack are registered one cycle ahead of the state they belong to,
  // so the bus sees only flops and the access is frozen at the grant edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel          <= 1'b0;
      cmd_wr       <= 1'b0;
      mmio_cs      <= 1'b0;
      mmio_wr      <= 1'b0;
      mmio_rd      <= 1'b0;
      mmio_addr    <= '0;
      mmio_wr_data <= '0;
      m_rd_data    <= '0;
      m_ack        <= '0;
    end else begin
      mmio_cs <= 1'b0;
      mmio_wr <= 1'b0;
      mmio_rd <= 1'b0;
      m_ack   <= '0;
      if (take) begin
        sel          <= gnt_idx;
        cmd_wr       <= m_wr[gnt_idx];
        mmio_addr    <= m_addr[gnt_idx];
        mmio_wr_data <= m_wr_data[gnt_idx];
        mmio_cs      <= 1'b1;
        mmio_wr      <= m_wr[gnt_idx];
        mmio_rd      <= ~m_wr[gnt_idx];
      end
      if (state == BUS) begin
        if (!cmd_wr) m_rd_data <= mmio_rd_data;
        m_ack <= sel ? 2'b10 : 2'b01;
      end
    end
  end
endmodule

// File: tb/tb_mmio_arbiter.sv
// Randomised and directed bench for mmio_arbiter against a grant-timestamp model.
module tb_mmio_arbiter;
  localparam int unsigned AW = 21;
  localparam int unsigned DW = 32;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [1:0]         m_req = '0;
  logic [1:0]         m_wr = '0;
  logic [1:0][AW-1:0] m_addr = '0;
  logic [1:0][DW-1:0] m_wr_data = '0;
  logic [1:0]         m_ack;
  logic [DW-1:0]      m_rd_data;
  logic               mmio_cs, mmio_wr, mmio_rd;
  logic [AW-1:0]      mmio_addr;
  logic [DW-1:0]      mmio_wr_data;
  logic [DW-1:0]      mmio_rd_data;

  int n_chk = 0;
  int n_fail = 0;

  mmio_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .m_req        (m_req),
    .m_wr         (m_wr),
    .m_addr       (m_addr),
    .m_wr_data    (m_wr_data),
    .m_ack        (m_ack),
    .m_rd_data    (m_rd_data),
    .mmio_cs      (mmio_cs),
    .mmio_wr      (mmio_wr),
    .mmio_rd      (mmio_rd),
    .mmio_addr    (mmio_addr),
    .mmio_wr_data (mmio_wr_data),
    .mmio_rd_data (mmio_rd_data)
  );

  always #5 clk = ~clk;

  // Slot contents: fixed pattern, with address 0x20 pinned to 0x12345678.
  function automatic logic [DW-1:0] slot_val(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (a == 21'h20) return 32'h1234_5678;
    v = {11'h0, a};
    return (v * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  assign mmio_rd_data = slot_val(mmio_addr);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an access is described by its grant edge g; the bus cycle follows
  // edge g, the ack follows edge g+1, and the next grant may happen at g+3.
  int            e = 0;
  int            g = -100;
  int            free_at = 0;
  int            gi = 0;
  bit            mptr = 1'b0;
  bit            gw = 1'b0;
  logic [AW-1:0] m_e_addr = '0;
  logic [DW-1:0] m_e_wd = '0;
  logic [DW-1:0] m_e_rd = '0;

  always @(posedge clk) begin
    logic [1:0] exp_ack;
    bit exp_cs;
    e++;
    if (reset) begin
      free_at  = e + 1;
      g        = -100;
      mptr     = 1'b0;
      m_e_addr = '0;
      m_e_wd   = '0;
      m_e_rd   = '0;
    end else begin
      if (e == g + 1 && !gw) m_e_rd = slot_val(m_e_addr);
      if (e >= free_at && m_req != 2'b00) begin
        if (m_req == 2'b11) gi = mptr ? 1 : 0;
        else                gi = m_req[1] ? 1 : 0;
        mptr     = (gi == 0);
        g        = e;
        gw       = m_wr[gi];
        m_e_addr = m_addr[gi];
        m_e_wd   = m_wr_data[gi];
        free_at  = e + 3;
      end
    end
    #1;
    exp_cs  = (e == g);
    exp_ack = (e == g + 1) ? ((gi == 1) ? 2'b10 : 2'b01) : 2'b00;
    chk("cs",        64'(mmio_cs),      64'(exp_cs));
    chk("wr",        64'(mmio_wr),      64'(exp_cs && gw));
    chk("rd",        64'(mmio_rd),      64'(exp_cs && !gw));
    chk("addr",      64'(mmio_addr),    64'(m_e_addr));
    chk("wr_data",   64'(mmio_wr_data), 64'(m_e_wd));
    chk("ack",       64'(m_ack),        64'(exp_ack));
    chk("rd_data",   64'(m_rd_data),    64'(m_e_rd));
  end

  task automatic idle(input int n);
    m_req = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic new_tx(input int i);
    m_req[i]       = 1'b1;
    m_wr[i]        = 1'($urandom_range(1, 0));
    m_addr[i]      = AW'($urandom_range(63, 0));
    m_wr_data[i]   = $urandom;
  endtask

  initial begin
    int acks, last, first;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ack",     64'(m_ack),        64'h0);
    chk("rst_cs",      64'(mmio_cs),      64'h0);
    chk("rst_addr",    64'(mmio_addr),    64'h0);
    chk("rst_wdata",   64'(mmio_wr_data), 64'h0);
    chk("rst_rdata",   64'(m_rd_data),    64'h0);
    @(negedge clk);

    // Single write from master 0
    m_req = 2'b01; m_wr = 2'b01; m_addr[0] = 21'h00041; m_wr_data[0] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("w_cs",    64'(mmio_cs),      64'h1);
    chk("w_wr",    64'(mmio_wr),      64'h1);
    chk("w_rd",    64'(mmio_rd),      64'h0);
    chk("w_addr",  64'(mmio_addr),    64'h41);
    chk("w_data",  64'(mmio_wr_data), 64'hDEADBEEF);
    chk("model_addr_pin", 64'(m_e_addr), 64'h41);
    @(posedge clk); #1;
    chk("w_ack",   64'(m_ack),        64'h1);
    chk("w_rdata", 64'(m_rd_data),    64'h0);
    @(negedge clk);
    idle(2);

    // Single read from master 1
    m_req = 2'b10; m_wr = 2'b00; m_addr[1] = 21'h00020;
    @(posedge clk); #1;
    chk("r_rd",    64'(mmio_rd),      64'h1);
    chk("r_wr",    64'(mmio_wr),      64'h0);
    @(posedge clk); #1;
    chk("r_ack",   64'(m_ack),        64'h2);
    chk("r_rdata", 64'(m_rd_data),    64'h12345678);
    chk("model_rd_pin", 64'(m_e_rd),  64'h12345678);
    chk("r_rd_off", 64'(mmio_rd),     64'h0);
    @(negedge clk);
    idle(2);

    // Contention from reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_req = 2'b11; m_wr = 2'b11;
    m_addr[0] = 21'h100; m_addr[1] = 21'h200;
    acks = 0; last = 0; first = 0;
    for (int c = 1; c <= 16 && acks < 4; c++) begin
      @(posedge clk); #1;
      if (m_ack != 2'b00) begin
        chk("cont_order", 64'(m_ack), (acks % 2 == 0) ? 64'h1 : 64'h2);
        if (acks == 0) first = c;
        else chk("cont_spacing", 64'(c - last), 64'd3);
        last = c;
        acks++;
      end
    end
    chk("cont_count", 64'(acks), 64'd4);
    chk("cont_first", 64'(first), 64'd2);
    @(negedge clk);
    idle(3);

    // Address change during the bus cycle must not reach the bus
    m_req = 2'b01; m_wr = 2'b01; m_addr[0] = 21'h10;
    @(posedge clk); #1;
    chk("mid_addr_bus", 64'(mmio_addr), 64'h10);
    m_addr[0] = 21'h20;
    @(posedge clk); #1;
    chk("mid_addr_ack", 64'(mmio_addr), 64'h10);
    chk("mid_ack",      64'(m_ack),     64'h1);
    @(negedge clk);
    idle(3);

    // Reset during the bus cycle aborts the access
    m_req = 2'b11; m_wr = 2'b00;
    m_addr[0] = 21'h55; m_addr[1] = 21'h33;
    @(posedge clk); #1;
    chk("rm_cs",   64'(mmio_cs),   64'h1);
    chk("rm_m1",   64'(mmio_addr), 64'h33);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rm_cs_off", 64'(mmio_cs), 64'h0);
    chk("rm_rd_off", 64'(mmio_rd), 64'h0);
    chk("rm_no_ack", 64'(m_ack),   64'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rm_regrant", 64'(mmio_addr), 64'h55);
    @(posedge clk); #1;
    chk("rm_ack_m0",  64'(m_ack),     64'h1);
    @(negedge clk);
    idle(3);

    // Quiet bus
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("idle_quiet", 64'({mmio_cs, m_ack}), 64'h0);
    end
    @(negedge clk);

    // Randomised traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(199, 0) == 0);
      for (int i = 0; i < 2; i++) begin
        if (m_ack[i]) begin
          if ($urandom_range(1, 0) == 1) new_tx(i);
          else m_req[i] = 1'b0;
        end else if (!m_req[i]) begin
          if ($urandom_range(9, 0) < 3) new_tx(i);
        end else begin
          if ($urandom_range(19, 0) == 0) m_addr[i] = AW'($urandom_range(63, 0));
          if ($urandom_range(19, 0) == 0) m_wr_data[i] = $urandom;
          if ($urandom_range(49, 0) == 0) m_req[i] = 1'b0;
        end
      end
    end
    @(negedge clk);
    reset = 1'b0;
    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
